// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic sel_t inc_idx(input sel_t i_idx);
        int w_nxt;
        w_nxt = (int'(i_idx) + 1) % N_REQ;
        return sel_t'(w_nxt);
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr.
module rr_arb_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  sel_t             i_ptr,
    output sel_t             o_gnt_idx,
    output logic             o_gnt_any
);

    logic w_found;
    sel_t w_idx;

    always_comb begin
        o_gnt_idx = i_ptr;
        w_found   = 1'b0;
        w_idx     = i_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = i_ptr + sel_t'(k);
            if (!w_found && i_req[w_idx]) begin
                o_gnt_idx = w_idx;
                w_found   = 1'b1;
            end
        end
    end

    assign o_gnt_any = |i_req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with registered 4:1 output stage.
// RR_MUX_ARBITER_BURST_LOCK_EN adds i_in_last and burst locking.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       i_in_valid,
    input  logic [N_REQ*WIDTH-1:0] i_in_data,
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
    input  logic [N_REQ-1:0]       i_in_last,
`endif
    output logic [N_REQ-1:0]       o_in_ready,
    output logic                   o_out_valid,
    output logic [WIDTH-1:0]       o_out_data,
    output sel_t                   o_out_sel,
    input  logic                   i_out_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    sel_t             r_out_sel;
    sel_t             r_ptr;
    logic             w_load;
    logic             w_fire;
    logic [N_REQ-1:0] w_req;
    sel_t             w_gnt_idx;
    logic             w_gnt_any;
    logic [WIDTH-1:0] w_gnt_data;

`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
    logic r_locked;
    sel_t r_lock_id;

    // While a burst is open only its owner may be granted.
    assign w_req = r_locked
                 ? (i_in_valid & (N_REQ'(1) << r_lock_id))
                 : i_in_valid;
`else
    assign w_req = i_in_valid;
`endif

    rr_arb_pick u_pick (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    assign w_load     = !r_out_valid || i_out_ready;
    assign w_fire     = w_load && w_gnt_any && rst_n;
    assign w_gnt_data = i_in_data[w_gnt_idx*WIDTH +: WIDTH];
    assign o_in_ready = w_fire ? (N_REQ'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
            r_locked    <= 1'b0;
            r_lock_id   <= '0;
`endif
        end else if (w_load) begin
            if (w_gnt_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_sel   <= w_gnt_idx;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
                if (i_in_last[w_gnt_idx]) begin
                    r_ptr    <= inc_idx(w_gnt_idx);
                    r_locked <= 1'b0;
                end else begin
                    r_locked  <= 1'b1;
                    r_lock_id <= w_gnt_idx;
                end
`else
                r_ptr       <= inc_idx(w_gnt_idx);
`endif
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_rr_mux_arbiter;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     valid = '0;
    logic [4*W-1:0] data = '0;
    logic           ordy = 1'b0;
    logic [3:0]     rdy;
    logic           ov;
    logic [W-1:0]   od;
    logic [1:0]     os;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
    logic [3:0]     last = 4'hF;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (valid),
        .i_in_data   (data),
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
        .i_in_last   (last),
`endif
        .o_in_ready  (rdy),
        .o_out_valid (ov),
        .o_out_data  (od),
        .o_out_sel   (os),
        .i_out_ready (ordy)
    );

    typedef struct {
        logic [3:0]  v;
        logic [15:0] d;
        logic        r;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_sel;
        logic [3:0]  e_od;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        ordy  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [15:0] d,
                                input logic r, input logic [3:0] er,
                                input logic eov, input logic [1:0] es,
                                input logic [3:0] eod);
        vec_t t;
        t.v = v; t.d = d; t.r = r;
        t.e_rdy = er; t.e_ov = eov; t.e_sel = es; t.e_od = eod;
        return t;
    endfunction

    // Spec-level model state
    int          m_ptr;
    logic        m_ov;
    logic [3:0]  m_od;
    int          m_os;
    logic        m_locked;
    int          m_lid;

    function automatic int pick(input logic [3:0] req, input int p);
        for (int k = 0; k < 4; k++) begin
            if (req[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        // rotation 0..3,0 ; skip/wrap ; single requester ; idle ;
        // backpressure then no-bubble reload
        tv.push_back(mk(4'hF, 16'hDCBA, 1, 4'b0001, 1, 0, 4'hA));
        tv.push_back(mk(4'hF, 16'hDCBA, 1, 4'b0010, 1, 1, 4'hB));
        tv.push_back(mk(4'hF, 16'hDCBA, 1, 4'b0100, 1, 2, 4'hC));
        tv.push_back(mk(4'hF, 16'hDCBA, 1, 4'b1000, 1, 3, 4'hD));
        tv.push_back(mk(4'hF, 16'hDCBA, 1, 4'b0001, 1, 0, 4'hA));
        tv.push_back(mk(4'h4, 16'hDCBA, 1, 4'b0100, 1, 2, 4'hC));
        tv.push_back(mk(4'hA, 16'hDCBA, 1, 4'b1000, 1, 3, 4'hD));
        tv.push_back(mk(4'hA, 16'hDCBA, 1, 4'b0010, 1, 1, 4'hB));
        tv.push_back(mk(4'hA, 16'hDCBA, 1, 4'b1000, 1, 3, 4'hD));
        tv.push_back(mk(4'h4, 16'hD7BA, 1, 4'b0100, 1, 2, 4'h7));
        tv.push_back(mk(4'h4, 16'hD7BA, 1, 4'b0100, 1, 2, 4'h7));
        tv.push_back(mk(4'h4, 16'hD7BA, 1, 4'b0100, 1, 2, 4'h7));
        tv.push_back(mk(4'h0, 16'hD7BA, 1, 4'b0000, 0, 2, 4'h7));
        tv.push_back(mk(4'hF, 16'hDCBA, 0, 4'b1000, 1, 3, 4'hD));
        tv.push_back(mk(4'hF, 16'hDCBA, 0, 4'b0000, 1, 3, 4'hD));
        tv.push_back(mk(4'hF, 16'hDCBA, 0, 4'b0000, 1, 3, 4'hD));
        tv.push_back(mk(4'hF, 16'hDCBA, 0, 4'b0000, 1, 3, 4'hD));
        tv.push_back(mk(4'hF, 16'hDCBA, 1, 4'b0001, 1, 0, 4'hA));

        do_reset();
        chk("reset_ov", 32'(ov), 0);
        chk("reset_od", 32'(od), 0);
        chk("reset_sel", 32'(os), 0);
        chk("reset_rdy", 32'(rdy), 0);

        foreach (tv[i]) begin
            valid = tv[i].v;
            data  = tv[i].d;
            ordy  = tv[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(tv[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ov", i), 32'(ov), 32'(tv[i].e_ov));
            chk($sformatf("vec%0d_sel", i), 32'(os), 32'(tv[i].e_sel));
            chk($sformatf("vec%0d_od", i), 32'(od), 32'(tv[i].e_od));
        end

        // asynchronous reset mid-beat, no clock edge needed
        valid = 4'hF;
        ordy  = 1'b1;
        #2;
        chk("pre_arst_ov", 32'(ov), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ov", 32'(ov), 0);
        chk("arst_od", 32'(od), 0);
        chk("arst_sel", 32'(os), 0);
        chk("arst_rdy", 32'(rdy), 0);
        @(posedge clk);
        #1;
        valid = '0;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("idle_ov", 32'(ov), 0);
        end

`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
        do_reset();
        ordy  = 1'b1;
        valid = 4'b0011;
        data  = 16'h0021;
        for (int b = 0; b < 4; b++) begin
            last = (b == 2) ? 4'b0011 : 4'b0010;
            @(negedge clk);
            chk($sformatf("burst%0d_rdy", b), 32'(rdy),
                (b < 3) ? 32'h1 : 32'h2);
            @(posedge clk);
            #1;
            chk($sformatf("burst%0d_sel", b), 32'(os), (b < 3) ? 0 : 1);
        end
        valid = 4'hF;
        last  = 4'hF;
        @(negedge clk);
        chk("burst_ptr2", 32'(rdy), 32'h4);
        @(posedge clk);
        #1;
`endif

        // randomized traffic vs model
        do_reset();
        m_ptr = 0; m_ov = 0; m_od = '0; m_os = 0;
        m_locked = 0; m_lid = 0;
        for (int c = 0; c < 400; c++) begin
            logic       ld;
            logic [3:0] elig;
            int         g;
            logic [3:0] er;
            valid = 4'($urandom);
            data  = 16'($urandom);
            ordy  = ($urandom_range(0, 3) != 0);
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
            last  = 4'($urandom);
`endif
            ld   = !m_ov || ordy;
            elig = valid;
            if (m_locked) elig = valid & 4'(1 << m_lid);
            g  = pick(elig, m_ptr);
            er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
            @(negedge clk);
            chk("rand_rdy", 32'(rdy), 32'(er));
            @(posedge clk);
            #1;
            if (ld) begin
                if (g >= 0) begin
                    m_ov = 1;
                    m_od = data[g*W +: W];
                    m_os = g;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
                    if (last[g]) begin
                        m_ptr = (g + 1) % 4;
                        m_locked = 0;
                    end else begin
                        m_locked = 1;
                        m_lid = g;
                    end
`else
                    m_ptr = (g + 1) % 4;
`endif
                end else begin
                    m_ov = 0;
                end
            end
            chk("rand_ov", 32'(ov), 32'(m_ov));
            chk("rand_sel", 32'(os), 32'(m_os));
            chk("rand_od", 32'(od), 32'(m_od));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
